// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction RAM loader.
package instr_loader_pkg;

    localparam int         IMEM_AW = 12;
    localparam int         CKSUM_W = 32;
    localparam logic [3:0] WE_ALL  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } ilo_state_t;

endpackage

// File: rtl/ilo_cksum_acc.sv
// Clearable wrapping accumulator, used for both the write-side checksum
// and the read-back sum of the loader.
module ilo_cksum_acc
    import instr_loader_pkg::*;
#(
    parameter int W = CKSUM_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] r_sum;

    // Sum wraps modulo 2**W; clear wins over accumulate.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/instr_ram_loader.sv
// Streams program words into the instruction RAM write port, reads them
// back to confirm the checksum, and holds the CPU while doing so.
module instr_ram_loader
    import instr_loader_pkg::*;
#(
    parameter int AW = IMEM_AW
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [AW:0]  i_word_cnt,
    input  logic [31:0]  i_s_data,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [3:0]   o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [31:0]  o_ram_din,
    input  logic [31:0]  i_ram_dout,
    output logic         o_cpu_hold,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error,
    output logic [31:0]  o_checksum
);

    localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

    ilo_state_t          r_state;
    logic [AW:0]         r_target;
    logic [AW:0]         r_wr_cnt;
    logic [AW:0]         r_rd_cnt;
    logic [AW:0]         r_sum_cnt;
    logic [3:0]          r_ram_we;
    logic [AW-1:0]       r_ram_addr;
    logic [31:0]         r_ram_din;
    logic                r_rd_act;
    logic                r_dout_ok;
    logic                r_cmp;
    logic                r_done;
    logic                r_error;

    logic                w_idle_like;
    logic                w_start_zero;
    logic                w_start_bad;
    logic                w_start_load;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_sum_en;
    logic                w_last_sum;
    logic [CKSUM_W-1:0]  w_checksum;
    logic [CKSUM_W-1:0]  w_rd_sum;

    // ERROR accepts a new start exactly like IDLE does.
    assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_ERROR);
    assign w_start_zero = w_idle_like && i_start && (i_word_cnt == '0);
    assign w_start_bad  = w_idle_like && i_start && (i_word_cnt > MAX_WORDS);
    assign w_start_load = w_idle_like && i_start && !w_start_zero && !w_start_bad;

    assign w_accept    = (r_state == ST_LOAD) && i_s_valid;
    assign w_last_beat = w_accept && ((r_wr_cnt + ONE) == r_target);
    assign w_sum_en    = (r_state == ST_VERIFY) && r_dout_ok;
    assign w_last_sum  = w_sum_en && ((r_sum_cnt + ONE) == r_target);

    ilo_cksum_acc #(.W(CKSUM_W)) u_wr_sum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_start_load),
        .i_en   (w_accept),
        .i_data (i_s_data),
        .o_sum  (w_checksum)
    );

    ilo_cksum_acc #(.W(CKSUM_W)) u_rd_sum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_start_load),
        .i_en   (w_sum_en),
        .i_data (i_ram_dout),
        .o_sum  (w_rd_sum)
    );

    // Control FSM: start decode, load/verify sequencing, done pulse and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (w_start_zero) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_error <= 1'b0;
                    end else if (w_start_bad) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else if (w_start_load) begin
                        r_state  <= ST_LOAD;
                        r_error  <= 1'b0;
                        r_target <= i_word_cnt;
                    end
                end
                ST_LOAD: begin
                    if (w_last_beat) begin
                        r_state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (r_cmp) begin
                        if (w_rd_sum == w_checksum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port registers and word counters; the first VERIFY cycle still carries
    // the final write, so the read of address 0 is issued one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ram_we   <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_sum_cnt  <= '0;
            r_rd_act   <= 1'b0;
            r_dout_ok  <= 1'b0;
            r_cmp      <= 1'b0;
        end else begin
            r_ram_we <= '0;
            if (w_start_load) begin
                r_wr_cnt  <= '0;
                r_rd_cnt  <= '0;
                r_sum_cnt <= '0;
                r_rd_act  <= 1'b0;
                r_dout_ok <= 1'b0;
                r_cmp     <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                if (w_accept) begin
                    r_ram_we   <= WE_ALL;
                    r_ram_addr <= r_wr_cnt[AW-1:0];
                    r_ram_din  <= i_s_data;
                    r_wr_cnt   <= r_wr_cnt + ONE;
                end
            end else if (r_state == ST_VERIFY) begin
                r_dout_ok <= r_rd_act;
                r_cmp     <= w_last_sum;
                if (w_sum_en) begin
                    r_sum_cnt <= r_sum_cnt + ONE;
                end
                if (r_rd_cnt != r_target) begin
                    r_ram_addr <= r_rd_cnt[AW-1:0];
                    r_rd_act   <= 1'b1;
                    r_rd_cnt   <= r_rd_cnt + ONE;
                end else begin
                    r_ram_addr <= '0;
                    r_rd_act   <= 1'b0;
                end
            end
        end
    end

    assign o_s_ready  = (r_state == ST_LOAD);
    assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign o_cpu_hold = (r_state == ST_LOAD) || (r_state == ST_VERIFY) || (r_state == ST_ERROR);
    assign o_ram_we   = r_ram_we;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;
    assign o_done     = r_done;
    assign o_error    = r_error;
    assign o_checksum = w_checksum;

endmodule
